// File: rtl/sdram_test_sequencer.sv
// SDRAM self-test sequencer: debounced key, ordered reset/load/start strobes, timed wait for
// completion, sticky verdict flags and saturating run/error counters.
module sdram_test_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned PULSE_CYCLES    = 16,
  parameter int unsigned GAP_CYCLES      = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 50_000_000
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iBUTTON,
  input  logic        iLOOP,
  input  logic        iTEST_PASS,
  input  logic        iTEST_FAIL,
  input  logic        iTEST_COMPLETE,
  output logic        oSW_RST_n,
  output logic        oLOAD_n,
  output logic        oSTART_n,
  output logic        oBUSY,
  output logic        oPASS,
  output logic        oFAIL,
  output logic        oTIMEOUT,
  output logic [15:0] oRUN_COUNT,
  output logic [15:0] oERR_COUNT
);

  typedef enum logic [2:0] {
    StIdle, StSwRst, StGap1, StLoad, StGap2, StStart, StWait, StResult
  } state_e;

  localparam logic [31:0] PulseLd   = 32'(PULSE_CYCLES - 1);
  localparam logic [31:0] GapLd     = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TimeoutLd = 32'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [1:0]  sync_q;
  logic        deb_q, deb_d, press_q;
  logic [31:0] deb_cnt_q, deb_cnt_d;
  logic        sw_rst_n_q, sw_rst_n_d, load_n_q, load_n_d, start_n_q, start_n_d;
  logic        busy_q, busy_d, pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d;
  logic [15:0] run_cnt_q, run_cnt_d, err_cnt_q, err_cnt_d;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (deb_cnt_q == DEBOUNCE_CYCLES - 1) deb_d = sync_q[1];
      else deb_cnt_d = deb_cnt_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    unique case (state_q)
      StIdle: begin
        if (press_q) begin
          state_d = StSwRst;
          cnt_d   = PulseLd;
        end
      end
      StSwRst, StLoad: begin
        if (cnt_q == '0) begin
          state_d = (state_q == StSwRst) ? StGap1 : StGap2;
          cnt_d   = GapLd;
        end else cnt_d = cnt_q - 32'd1;
      end
      StGap1, StGap2: begin
        if (cnt_q == '0) begin
          state_d = (state_q == StGap1) ? StLoad : StStart;
          cnt_d   = PulseLd;
        end else cnt_d = cnt_q - 32'd1;
      end
      StStart: begin
        if (cnt_q == '0) begin
          state_d = StWait;
          cnt_d   = TimeoutLd;
        end else cnt_d = cnt_q - 32'd1;
      end
      StWait: begin
        // Completion takes priority over an expiring timeout.
        if (iTEST_COMPLETE) begin
          state_d = StResult;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = StResult;
          done_d  = 1'b0;
        end else cnt_d = cnt_q - 32'd1;
      end
      StResult: begin
        if (iLOOP) begin
          state_d = StSwRst;
          cnt_d   = PulseLd;
        end else state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pass_d    = pass_q;
    fail_d    = fail_q;
    tmo_d     = tmo_q;
    run_cnt_d = run_cnt_q;
    err_cnt_d = err_cnt_q;
    if (state_q == StResult) begin
      if (done_q) begin
        pass_d = iTEST_PASS & ~iTEST_FAIL;
        fail_d = ~pass_d;
        tmo_d  = 1'b0;
      end else begin
        pass_d = 1'b0;
        fail_d = 1'b0;
        tmo_d  = 1'b1;
      end
      if (run_cnt_q != 16'hFFFF) run_cnt_d = run_cnt_q + 16'd1;
      if (!pass_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end
    sw_rst_n_d = (state_d != StSwRst);
    load_n_d   = (state_d != StLoad);
    start_n_d  = (state_d != StStart);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      sync_q     <= 2'b11;
      deb_q      <= 1'b1;
      deb_cnt_q  <= '0;
      press_q    <= 1'b0;
      sw_rst_n_q <= 1'b1;
      load_n_q   <= 1'b1;
      start_n_q  <= 1'b1;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      tmo_q      <= 1'b0;
      run_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      sync_q     <= {sync_q[0], iBUTTON};
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      press_q    <= deb_q & ~deb_d;
      sw_rst_n_q <= sw_rst_n_d;
      load_n_q   <= load_n_d;
      start_n_q  <= start_n_d;
      busy_q     <= busy_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      tmo_q      <= tmo_d;
      run_cnt_q  <= run_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign oSW_RST_n  = sw_rst_n_q;
  assign oLOAD_n    = load_n_q;
  assign oSTART_n   = start_n_q;
  assign oBUSY      = busy_q;
  assign oPASS      = pass_q;
  assign oFAIL      = fail_q;
  assign oTIMEOUT   = tmo_q;
  assign oRUN_COUNT = run_cnt_q;
  assign oERR_COUNT = err_cnt_q;

endmodule

// File: doc/sdram_test_sequencer.md
# sdram_test_sequencer

Sequencer for the SDRAM read/write self-test. It debounces the user key and drives the test's three control strobes in a fixed order: the test-logic software reset, the controller FIFO address load (global reset) and the test start. It then waits for the test to finish, with a timeout, and latches the verdict. It also keeps run and error counters, so the board can soak-test the SDRAM in a continuous loop.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 2_000_000: number of consecutive stable samples needed to accept a new key level.
- PULSE_CYCLES, 16: width of each low strobe (oSW_RST_n, oLOAD_n, oSTART_n).
- GAP_CYCLES, 64: idle cycles between strobes.
- TIMEOUT_CYCLES, 50_000_000: maximum wait for completion after start.

Ports:
- iCLK, in, 1: single clock. All logic is on the rising edge.
- iRST_n, in, 1: asynchronous, active-low reset.
- iBUTTON, in, 1: raw key, active low, asynchronous to iCLK.
- iLOOP, in, 1: 1 = restart automatically after each result.
- iTEST_PASS, in, 1: pass status from the test engine.
- iTEST_FAIL, in, 1: fail status from the test engine.
- iTEST_COMPLETE, in, 1: test-complete status from the test engine.
- oSW_RST_n, out, 1: active-low reset to the test engine.
- oLOAD_n, out, 1: active-low address load to the SDRAM controller read and write ports.
- oSTART_n, out, 1: active-low start strobe to the test engine.
- oBUSY, out, 1: high in every state except IDLE.
- oPASS, out, 1: verdict of the last run, sticky.
- oFAIL, out, 1: verdict of the last run, sticky.
- oTIMEOUT, out, 1: the last run timed out, sticky.
- oRUN_COUNT, out, 16: completed runs, saturating.
- oERR_COUNT, out, 16: failed or timed-out runs, saturating.

## Operation
- Input conditioning: iBUTTON passes through a 2-flop synchronizer into a debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it.
  - A press event is a 1-cycle pulse on a 1→0 debounced transition.
- States: IDLE, SWRST, GAP1, LOAD, GAP2, START, WAIT, RESULT. One down-counter (≥26 bits) is shared by all timed states.
- IDLE: all strobes are high. A press event goes to SWRST.
- SWRST: oSW_RST_n=0 for PULSE_CYCLES cycles, then GAP1.
- GAP1: GAP_CYCLES cycles, then LOAD.
- LOAD: oLOAD_n=0 for PULSE_CYCLES cycles, then GAP2.
- GAP2: GAP_CYCLES cycles, then START.
- START: oSTART_n=0 for PULSE_CYCLES cycles, then WAIT.
- WAIT:
  - Counter loads TIMEOUT_CYCLES on entry.
  - iTEST_COMPLETE=1 goes to RESULT with verdict "completed".
  - Counter reaching 0 goes to RESULT with verdict "timeout".
  - Complete wins over timeout in the same cycle.
- RESULT (1 cycle): oPASS, oFAIL, oTIMEOUT, oRUN_COUNT and oERR_COUNT update as follows.
  - Completed run: oPASS = iTEST_PASS & ~iTEST_FAIL; oFAIL = ~oPASS; oTIMEOUT = 0.
  - Timeout: oPASS = 0; oFAIL = 0; oTIMEOUT = 1.
  - oRUN_COUNT += 1. oERR_COUNT += 1 unless the run passed.
  - Both counters saturate at 16'hFFFF and never wrap.
  - Next state is SWRST if iLOOP=1, otherwise IDLE.
- Press events outside IDLE are discarded; they are not queued.
- Deasserting iLOOP mid-run finishes the current run and then returns to IDLE.
- The verdict outputs stay valid across the next run. They change only in RESULT.
- iTEST_COMPLETE is ignored outside WAIT, so a stale complete flag from the previous run cannot end a new run. The software reset clears the flag before WAIT is entered.

## Timing
- Reset: the state is IDLE.
  - Outputs: oSW_RST_n=1, oLOAD_n=1, oSTART_n=1, oBUSY=0, oPASS=0, oFAIL=0, oTIMEOUT=0, both counters 0.
  - Synchronizer and debounced level preset to 1 (key released).
- All outputs are registered. Strobes have no combinational path from any input.
- Key to strobe:
  - A key edge on iBUTTON reaches the debounced level after 2 synchronizer cycles plus DEBOUNCE_CYCLES.
  - oSW_RST_n falls on the cycle after the press event.
- Sequence from the first oSW_RST_n=0 cycle (cycle 0):
  - oLOAD_n falls at cycle PULSE_CYCLES+GAP_CYCLES.
  - oSTART_n falls at cycle 2·(PULSE_CYCLES+GAP_CYCLES).
  - Each strobe is exactly PULSE_CYCLES wide. No two strobes are ever low together.
- WAIT→RESULT:
  - Verdict registers and counters update on the edge that leaves RESULT.
  - They are visible 2 cycles after the iTEST_COMPLETE sample that triggered the exit.
- Timeout: RESULT is entered TIMEOUT_CYCLES+1 cycles after WAIT is entered.
- Loop restart: oSW_RST_n falls on the cycle after RESULT.
- Reset mid-operation: iRST_n=0 forces the reset values immediately, with no waiting for the clock. Any strobe that is low is released at once.

## Test plan
Benches override the parameters: DEBOUNCE_CYCLES=8, PULSE_CYCLES=4, GAP_CYCLES=6, TIMEOUT_CYCLES=100.
- Press with a 5-cycle bounce, then a stable low → exactly one sequence.
  - Strobes fall at cycles 0, 10 and 20, each 4 cycles wide, with no overlap.
  - oBUSY=1 from cycle 0.
- iTEST_COMPLETE=1 and iTEST_PASS=1 at 30 cycles after WAIT entry → oPASS=1, oFAIL=0, oRUN_COUNT=1, oERR_COUNT=0.
  - The state returns to IDLE and oBUSY=0.
- iTEST_COMPLETE never asserts → RESULT 101 cycles after WAIT entry.
  - oTIMEOUT=1, oPASS=0, oERR_COUNT=1.
- iLOOP=1 with the engine alternating pass and fail over 4 runs → oRUN_COUNT=4, oERR_COUNT=2.
  - Saturation check: force oRUN_COUNT to 16'hFFFE, run 3 passes → count holds at 16'hFFFF.
- Stale iTEST_COMPLETE=1 held through SWRST..START, and a second press during WAIT → no early exit, no second sequence.
- iRST_n pulsed low mid-LOAD → oLOAD_n=1 and every output at its reset value within the same cycle.
  - The next press starts a clean sequence.
